run_sequencer: RTL
==================

RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the cycle and instruction counters.
REQ-002 SHALL have parameter TIMEOUT, default 40000, the cycle budget before forced stop.
REQ-003 SHALL have port Clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Req  input  1  bench start request, level-sensitive, four-phase with Done.
REQ-006 SHALL have port CtrlAck  input  1  halt decoded from the decoder (all-ones instruction).
REQ-007 SHALL have port CtrlLoad  input  1  current instruction is a load.
REQ-008 SHALL have port CtrlRegWrEn  input  1  raw register-write enable from the decoder.
REQ-009 SHALL have port CtrlMemWrEn  input  1  raw memory-write enable from the decoder.
REQ-010 SHALL have port PCInit  output  1  loads the PC with the program start address.
REQ-011 SHALL have port PCEn  output  1  advances or branches the PC this cycle.
REQ-012 SHALL have port RegWrEn  output  1  gated register-file write enable.
REQ-013 SHALL have port MemWrEn  output  1  gated data-memory write enable.
REQ-014 SHALL have port Busy  output  1  program executing (EXEC or LWAIT).
REQ-015 SHALL have port Done  output  1  program finished; held until Req falls.
REQ-016 SHALL have port Timeout  output  1  finish was forced by TIMEOUT.
REQ-017 SHALL have port CycleCount  output  CNT_W  execution cycles of the current or last run.
REQ-018 SHALL have port InstCount  output  CNT_W  instructions retired in the current or last run.

Function
REQ-019 SHALL implement states IDLE, INIT, EXEC, LWAIT and DONE.
REQ-020 In IDLE, Req=1 SHALL move to INIT; otherwise the FSM SHALL stay in IDLE. All enables SHALL be 0 in IDLE.
REQ-021 INIT SHALL last exactly one cycle with PCInit=1. It SHALL clear both counters and Timeout, then go to EXEC.
REQ-022 EXEC with CtrlAck=1 SHALL go to DONE with PCEn=RegWrEn=MemWrEn=0. CtrlAck SHALL have priority over all other conditions.
REQ-023 EXEC with CtrlLoad=1 SHALL go to LWAIT with PCEn=0 and RegWrEn=0 (one-cycle registered memory read).
REQ-024 In any other EXEC cycle, PCEn SHALL be 1, RegWrEn SHALL equal CtrlRegWrEn, MemWrEn SHALL equal CtrlMemWrEn, and the FSM SHALL stay in EXEC.
REQ-025 LWAIT SHALL drive PCEn=1, RegWrEn=CtrlRegWrEn and MemWrEn=0, then return to EXEC.
REQ-026 CycleCount SHALL increment by 1 on every EXEC or LWAIT cycle, including the cycle that sees CtrlAck.
REQ-027 InstCount SHALL increment in every EXEC cycle covered by REQ-024 and in every LWAIT cycle, so that a load counts once.
REQ-028 In an EXEC or LWAIT cycle with CycleCount == TIMEOUT-1 and CtrlAck=0:
  - that cycle's outputs SHALL be produced normally;
  - the next state SHALL be DONE with Timeout=1;
  - CycleCount SHALL never exceed TIMEOUT.
REQ-029 Both counters SHALL saturate at all-ones. They SHALL hold their values in LWAIT-free idle states (IDLE, DONE), so results stay readable after the run.
REQ-030 DONE SHALL drive Done=1 and stay in DONE while Req=1. Req=0 SHALL move to IDLE, which deasserts Done.
REQ-031 Req changes during INIT, EXEC or LWAIT SHALL be ignored, with no abort and no restart.
REQ-032 Busy SHALL be 1 exactly in EXEC and LWAIT. All outputs SHALL be registered or decoded from the state and the current Ctrl* inputs only, with no combinational path from Req.

Reset
REQ-033 Reset_n=0 SHALL immediately force IDLE and set every output and both counters to 0, including during a run.
REQ-034 After Reset_n rises, the block SHALL not leave IDLE before the first rising Clk edge with Req=1.

Structure
REQ-035 The state enum run_state_t SHALL live in the shared definitions package, and TIMEOUT's default SHALL be defined there as a constant.
REQ-036 The two counters SHALL each be one instance of sub-module sat_counter, which has parameter width and inputs clr, inc and the saturate limit.
REQ-037 The top level SHALL gate the decoder's RegWrEn and MemWrEn only through this block.

Verification
REQ-038 Reset released, Req=1; stream of 5 non-load ALU ops, then Ack -> PCInit for 1 cycle; PCEn=1 for 5 cycles; Done=1; CycleCount=6, InstCount=5.
REQ-039 Stream of ALU, load, ALU, then Ack -> load holds PCEn=0 then 1; RegWrEn only in the LWAIT cycle for the load; CycleCount=5, InstCount=3.
REQ-040 TIMEOUT=8, program never halts -> DONE after exactly 8 execution cycles; Timeout=1, CycleCount=8.
REQ-041 Hold Req=1 through DONE for 10 cycles, then drop, then raise again -> Done stays 1; IDLE follows; INIT clears counters and Timeout; second run counts from 0.
REQ-042 Assert Reset_n=0 mid-run during LWAIT -> all outputs 0 asynchronously, before the next Clk edge; FSM in IDLE.
REQ-043 Store (CtrlMemWrEn=1) in the same cycle as Ack -> MemWrEn=0; Req toggled mid-run -> no restart.

Source files
------------

// File: rtl/run_sequencer_pkg.sv
// Shared definitions for the run sequencer:
// FSM state encoding and the default cycle budget.
package run_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_EXEC,
      S_LWAIT,
      S_DONE
   } run_state_t;

   localparam int TIMEOUT_DEF = 40000;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that stops at a limit.
// Used for the cycle and instruction counters.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q < limit)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/run_sequencer.sv
// Run sequencer: starts a program on Req, gates decoder
// write enables, counts cycles/instructions, forces stop.
module run_sequencer
   import run_sequencer_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Req,
   input  logic             CtrlAck,
   input  logic             CtrlLoad,
   input  logic             CtrlRegWrEn,
   input  logic             CtrlMemWrEn,
   output logic             PCInit,
   output logic             PCEn,
   output logic             RegWrEn,
   output logic             MemWrEn,
   output logic             Busy,
   output logic             Done,
   output logic             Timeout,
   output logic [CNT_W-1:0] CycleCount,
   output logic [CNT_W-1:0] InstCount
);

   localparam longint MAX_CNT =
      (64'(1) << CNT_W) - 64'(1);
   localparam longint CYC_LIM =
      (longint'(TIMEOUT) < MAX_CNT) ?
      longint'(TIMEOUT) : MAX_CNT;
   localparam longint LAST = longint'(TIMEOUT) - 1;

   run_state_t state_q;
   run_state_t state_d;
   logic       timeout_q;
   logic       timeout_d;
   logic       cnt_clr;
   logic       cyc_inc;
   logic       inst_inc;
   logic       cyc_last;

   assign cyc_last = (longint'(CycleCount) == LAST);

   always_comb begin
      state_d   = state_q;
      timeout_d = timeout_q;
      PCEn      = 1'b0;
      RegWrEn   = 1'b0;
      MemWrEn   = 1'b0;
      cnt_clr   = 1'b0;
      cyc_inc   = 1'b0;
      inst_inc  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (Req) state_d = S_INIT;
         end
         S_INIT: begin
            cnt_clr   = 1'b1;
            timeout_d = 1'b0;
            state_d   = S_EXEC;
         end
         S_EXEC: begin
            cyc_inc = 1'b1;
            if (CtrlAck) begin
               state_d = S_DONE;
            end else begin
               if (CtrlLoad) begin
                  state_d = S_LWAIT;
               end else begin
                  PCEn     = 1'b1;
                  RegWrEn  = CtrlRegWrEn;
                  MemWrEn  = CtrlMemWrEn;
                  inst_inc = 1'b1;
               end
               if (cyc_last) begin
                  state_d   = S_DONE;
                  timeout_d = 1'b1;
               end
            end
         end
         S_LWAIT: begin
            // halt cannot be decoded here; the load is still in flight
            cyc_inc  = 1'b1;
            inst_inc = 1'b1;
            PCEn     = 1'b1;
            RegWrEn  = CtrlRegWrEn;
            state_d  = S_EXEC;
            if (cyc_last) begin
               state_d   = S_DONE;
               timeout_d = 1'b1;
            end
         end
         S_DONE: begin
            if (!Req) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= S_IDLE;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timeout_q <= timeout_d;
      end
   end

   assign PCInit  = (state_q == S_INIT);
   assign Busy    = (state_q == S_EXEC) ||
                    (state_q == S_LWAIT);
   assign Done    = (state_q == S_DONE);
   assign Timeout = timeout_q;

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_cyc_cnt (
      .clk   (Clk),
      .rst_n (Reset_n),
      .clr   (cnt_clr),
      .inc   (cyc_inc),
      .limit (CNT_W'(CYC_LIM)),
      .count (CycleCount)
   );

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_inst_cnt (
      .clk   (Clk),
      .rst_n (Reset_n),
      .clr   (cnt_clr),
      .inc   (inst_inc),
      .limit ({CNT_W{1'b1}}),
      .count (InstCount)
   );

endmodule
